bitwise_logic_unit: RTL and testbench
=====================================

BITWISE_LOGIC_UNIT -- requirements
Module: bitwise_logic_unit

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (legal 1..64).
REQ-002 Parameter: CNT_W, 16, width of the completed-transaction counter.
REQ-003 Port: clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-005 Port: in_valid  input  1  operand set presented.
REQ-006 Port: in_ready  output  1  unit accepts operand set this cycle.
REQ-007 Port: a, b  input  WIDTH each  operands.
REQ-008 Port: op  input  3  operation select, per REQ-013.
REQ-009 Port: acc_sel  input  1  when 1, operand b SHALL be replaced by the accumulator.
REQ-010 Port: acc_clr  input  1  clears the accumulator.
REQ-011 Port: out_valid  output  1; out_ready  input  1; y  output  WIDTH  result; zero  output  1  (y==0); parity  output  1  (XOR-reduce of y); ones  output  clog2(WIDTH+1)  population count of y; count  output  CNT_W  completed output handshakes.

Function
REQ-012 Two-stage pipeline: S1 registers {a, b, op, acc_sel}; S2 registers {y, zero, parity, ones}; out_valid SHALL equal S2 valid.
REQ-013 op encoding: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT a (b ignored), 111 pass a.
REQ-014 Input handshake: transfer when in_valid && in_ready; S1 SHALL load only on transfer.
REQ-015 Advance: S1->S2 when S1 valid && (!S2 valid || out_ready); in_ready SHALL equal !S1 valid || advance (combinational, no dependence on in_valid).
REQ-016 Output handshake: transfer when out_valid && out_ready; S2 valid SHALL clear on transfer unless a new advance loads it the same cycle.
REQ-017 Latency: accepted input SHALL appear on y two cycles after acceptance when out_ready is held 1; throughput one result per cycle.
REQ-018 Backpressure: with out_ready=0, y and all flags SHALL hold stable while out_valid=1; at most two operand sets are held; no set SHALL be dropped or duplicated.
REQ-019 Result y, zero, parity, ones SHALL be computed from S1 contents at the advance and registered into S2; flags are consistent with y.
REQ-020 Accumulator: WIDTH-bit register; when S1 acc_sel=1, b operand SHALL be the accumulator value at the advance edge; on that advance the accumulator SHALL load the computed y.
REQ-021 Back-to-back acc_sel operations SHALL chain with no bubble: each uses the result of the preceding accumulate operation.
REQ-022 acc_clr=1 SHALL set accumulator to 0 at the next edge; if coincident with an accumulator load, clear SHALL win; it SHALL not affect S1/S2 contents or the value in flight.
REQ-023 count SHALL increment by 1 per output transfer and wrap from 2^CNT_W-1 to 0.
REQ-024 Operations with acc_sel=0 SHALL neither read nor modify the accumulator.

Reset
REQ-025 On reset: S1 valid=0, S2 valid=0, out_valid=0, y=0, zero=1, parity=0, ones=0, accumulator=0, count=0; in_ready SHALL be 1 the first cycle after reset deasserts.
REQ-026 Reset SHALL override any concurrent handshake; operand sets in flight SHALL be discarded and not counted.
REQ-027 While reset=1, in_ready SHALL be 0 and out_valid 0.

Verification (WIDTH=8 unless stated)
REQ-028 a=8'hF0, b=8'h3C, op=011, out_ready=1 -> two cycles later y=8'hCF, zero=0, parity=0, ones=6, count=1.
REQ-029 acc_clr, then acc_sel=1, op=010, a=8'h01, 8'h03, 8'h02 on consecutive cycles -> y=8'h01, 8'h02, 8'h00 on consecutive cycles; last zero=1; accumulator=0.
REQ-030 out_ready=0, in_valid=1 with three distinct sets -> first two accepted, in_ready=0 thereafter; y holds first result; releasing out_ready yields all three in order, count=3.
REQ-031 WIDTH=1, sweep {a,b} through 00,01,10,11 for each of the 8 ops -> y matches REQ-013 truth table for all 32 cases.
REQ-032 Reset asserted with both stages valid -> next cycle out_valid=0, count=0, accumulator=0, y=0; subsequent acc_sel op with a=8'h5A, op=001 -> y=8'h5A.
REQ-033 CNT_W=2, five output transfers -> count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/bitwise_logic_unit.sv
// Two-stage bitwise logic pipeline with valid/ready handshakes, result flags,
// an optional accumulator operand and a completed-transfer counter.
module bitwise_logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  localparam int ONES_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [2:0]        op,
  input  logic              acc_sel,
  input  logic              acc_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  y,
  output logic              zero,
  output logic              parity,
  output logic [ONES_W-1:0] ones,
  output logic [CNT_W-1:0]  count
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_acc_sel;
  logic             s2_valid;
  logic [WIDTH-1:0] acc;

  logic              advance;
  logic              in_xfer;
  logic              out_xfer;
  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH-1:0]  result;
  logic [ONES_W-1:0] result_ones;

  // Both handshakes are masked during reset so nothing transfers while flushing.
  assign advance   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !reset && (!s1_valid || advance);
  assign out_valid = !reset && s2_valid;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    b_eff = s1_acc_sel ? acc : s1_b;
    case (s1_op)
      3'b000:  result = s1_a & b_eff;
      3'b001:  result = s1_a | b_eff;
      3'b010:  result = s1_a ^ b_eff;
      3'b011:  result = ~(s1_a & b_eff);
      3'b100:  result = ~(s1_a | b_eff);
      3'b101:  result = ~(s1_a ^ b_eff);
      3'b110:  result = ~s1_a;
      default: result = s1_a;
    endcase
  end

  always_comb begin
    result_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      result_ones = result_ones + ONES_W'(result[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      s1_acc_sel <= 1'b0;
      s2_valid   <= 1'b0;
      y          <= '0;
      zero       <= 1'b1;
      parity     <= 1'b0;
      ones       <= '0;
      acc        <= '0;
      count      <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid   <= 1'b1;
        s1_a       <= a;
        s1_b       <= b;
        s1_op      <= op;
        s1_acc_sel <= acc_sel;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end

      if (advance) begin
        s2_valid <= 1'b1;
        y        <= result;
        zero     <= (result == '0);
        parity   <= ^result;
        ones     <= result_ones;
      end else if (out_xfer) begin
        s2_valid <= 1'b0;
      end

      // Clear beats a same-edge accumulate load.
      if (acc_clr) begin
        acc <= '0;
      end else if (advance && s1_acc_sel) begin
        acc <= result;
      end

      if (out_xfer) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed self-checking bench for bitwise_logic_unit: default 8-bit instance,
// a 1-bit instance for the op truth table and a 2-bit counter instance for wrap.
module tb_bitwise_logic_unit;

  logic clk;
  logic reset;

  logic       in_valid, in_ready, acc_sel, acc_clr, out_valid, out_ready;
  logic [7:0] a, b, y;
  logic [2:0] op;
  logic       zero, parity;
  logic [3:0] ones;
  logic [15:0] count;

  logic       w_in_valid, w_in_ready, w_out_valid, w_zero, w_parity;
  logic [0:0] w_a, w_b, w_y, w_ones;
  logic [2:0] w_op;
  logic [15:0] w_count;

  logic       c_in_valid, c_in_ready, c_out_valid, c_zero, c_parity;
  logic [7:0] c_a, c_y;
  logic [3:0] c_ones;
  logic [1:0] c_count;

  int checks;
  int errors;

  bitwise_logic_unit #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_sel(acc_sel), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero),
    .parity(parity), .ones(ones), .count(count)
  );

  bitwise_logic_unit #(.WIDTH(1), .CNT_W(16)) dut_w1 (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .op(w_op), .acc_sel(1'b0), .acc_clr(1'b0),
    .out_valid(w_out_valid), .out_ready(1'b1), .y(w_y), .zero(w_zero),
    .parity(w_parity), .ones(w_ones), .count(w_count)
  );

  bitwise_logic_unit #(.WIDTH(8), .CNT_W(2)) dut_cnt (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .a(c_a), .b(8'h00), .op(3'b111), .acc_sel(1'b0), .acc_clr(1'b0),
    .out_valid(c_out_valid), .out_ready(1'b1), .y(c_y), .zero(c_zero),
    .parity(c_parity), .ones(c_ones), .count(c_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid = 0; a = 0; b = 0; op = 0; acc_sel = 0; acc_clr = 0; out_ready = 1;
  endtask

  task automatic test_reset;
    reset = 1;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (y !== 8'h00) begin errors++; $display("[TB] FAIL rst_y: got %h want 00", y); end
    checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL rst_zero: got %b want 1", zero); end
    checks++; if (parity !== 1'b0) begin errors++; $display("[TB] FAIL rst_parity: got %b want 0", parity); end
    checks++; if (ones !== 4'd0) begin errors++; $display("[TB] FAIL rst_ones: got %0d want 0", ones); end
    checks++; if (count !== 16'd0) begin errors++; $display("[TB] FAIL rst_count: got %0d want 0", count); end
    tick();
    reset = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_nand;
    tick();
    in_valid = 1; a = 8'hF0; b = 8'h3C; op = 3'b011; out_ready = 1;
    tick();
    in_valid = 0;
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL nand_out_valid: got %b want 1", out_valid); end
    checks++; if (y !== 8'hCF) begin errors++; $display("[TB] FAIL nand_y: got %h want cf", y); end
    checks++; if (zero !== 1'b0) begin errors++; $display("[TB] FAIL nand_zero: got %b want 0", zero); end
    checks++; if (parity !== 1'b0) begin errors++; $display("[TB] FAIL nand_parity: got %b want 0", parity); end
    checks++; if (ones !== 4'd6) begin errors++; $display("[TB] FAIL nand_ones: got %0d want 6", ones); end
    tick();
    @(negedge clk);
    checks++; if (count !== 16'd1) begin errors++; $display("[TB] FAIL nand_count: got %0d want 1", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL nand_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_ops;
    logic [7:0] exp_y [8];
    logic [3:0] exp_ones [8];
    exp_y    = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};
    exp_ones = '{4'd2, 4'd6, 4'd4, 4'd6, 4'd2, 4'd4, 4'd4, 4'd4};
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        in_valid = 1; a = 8'hF0; b = 8'h3C; op = 3'(i);
      end else begin
        in_valid = 0;
      end
      @(negedge clk);
      if (i >= 2) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ops_out_valid[%0d]: got %b want 1", i - 2, out_valid); end
        checks++; if (y !== exp_y[i-2]) begin errors++; $display("[TB] FAIL ops_y[%0d]: got %h want %h", i - 2, y, exp_y[i-2]); end
        checks++; if (ones !== exp_ones[i-2]) begin errors++; $display("[TB] FAIL ops_ones[%0d]: got %0d want %0d", i - 2, ones, exp_ones[i-2]); end
      end
      tick();
    end
    @(negedge clk);
    checks++; if (count !== 16'd9) begin errors++; $display("[TB] FAIL ops_count: got %0d want 9", count); end
  endtask

  task automatic test_accumulate;
    // {valid, a, op, acc_sel, acc_clr, expected y}
    logic        t_v   [12];
    logic [7:0]  t_a   [12];
    logic [2:0]  t_op  [12];
    logic        t_sel [12];
    logic        t_clr [12];
    logic [7:0]  t_y   [12];
    t_v   = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0};
    t_a   = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h55, 8'hAA, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00};
    t_op  = '{3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd7, 3'd2, 3'd2, 3'd0, 3'd2, 3'd0, 3'd0};
    t_sel = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 1, 0, 0};
    t_clr = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    t_y   = '{8'h00, 8'h01, 8'h02, 8'h00, 8'h55, 8'hAA, 8'h55, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    tick();
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      in_valid = t_v[i]; a = t_a[i]; b = 8'hFF; op = t_op[i]; acc_sel = t_sel[i]; acc_clr = t_clr[i];
      @(negedge clk);
      if (i >= 2) begin
        checks++; if (out_valid !== t_v[i-2]) begin errors++; $display("[TB] FAIL acc_out_valid[%0d]: got %b want %b", i - 2, out_valid, t_v[i-2]); end
        if (t_v[i-2]) begin
          checks++; if (y !== t_y[i-2]) begin errors++; $display("[TB] FAIL acc_y[%0d]: got %h want %h", i - 2, y, t_y[i-2]); end
          checks++; if (zero !== (t_y[i-2] == 8'h00)) begin errors++; $display("[TB] FAIL acc_zero[%0d]: got %b want %b", i - 2, zero, (t_y[i-2] == 8'h00)); end
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_flush;
    tick();
    out_ready = 0;
    in_valid = 1; acc_sel = 1; op = 3'b111; a = 8'hFF; b = 8'h00;
    tick();
    acc_sel = 0; a = 8'h3C;
    tick();
    in_valid = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_full_out_valid: got %b want 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_full_in_ready: got %b want 0", in_ready); end
    tick();
    reset = 1; out_ready = 1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_rst_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_rst_in_ready: got %b want 0", in_ready); end
    tick();
    reset = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid: got %b want 0", out_valid); end
    checks++; if (count !== 16'd0) begin errors++; $display("[TB] FAIL flush_count: got %0d want 0", count); end
    checks++; if (y !== 8'h00) begin errors++; $display("[TB] FAIL flush_y: got %h want 00", y); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1; acc_sel = 1; op = 3'b001; a = 8'h5A; b = 8'h81;
    tick();
    in_valid = 0; acc_sel = 0;
    tick();
    @(negedge clk);
    checks++; if (y !== 8'h5A) begin errors++; $display("[TB] FAIL flush_acc_y: got %h want 5a", y); end
    tick();
    @(negedge clk);
    checks++; if (count !== 16'd1) begin errors++; $display("[TB] FAIL flush_count_after: got %0d want 1", count); end
  endtask

  task automatic test_backpressure;
    tick();
    reset = 1;
    idle_inputs();
    tick();
    reset = 0;
    out_ready = 0;
    in_valid = 1; a = 8'h11; b = 8'h22; op = 3'b001;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready0: got %b want 1", in_ready); end
    tick();
    a = 8'h44; b = 8'h0F; op = 3'b000;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready1: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid1: got %b want 0", out_valid); end
    tick();
    a = 8'hAA; b = 8'h55; op = 3'b010;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready2: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid2: got %b want 1", out_valid); end
    checks++; if (y !== 8'h33) begin errors++; $display("[TB] FAIL bp_y2: got %h want 33", y); end
    tick();
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready3: got %b want 0", in_ready); end
    checks++; if (y !== 8'h33) begin errors++; $display("[TB] FAIL bp_hold_y: got %h want 33", y); end
    checks++; if (ones !== 4'd4) begin errors++; $display("[TB] FAIL bp_hold_ones: got %0d want 4", ones); end
    tick();
    out_ready = 1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready4: got %b want 1", in_ready); end
    checks++; if (y !== 8'h33) begin errors++; $display("[TB] FAIL bp_y4: got %h want 33", y); end
    tick();
    in_valid = 0;
    @(negedge clk);
    checks++; if (y !== 8'h04) begin errors++; $display("[TB] FAIL bp_y5: got %h want 04", y); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid5: got %b want 1", out_valid); end
    tick();
    @(negedge clk);
    checks++; if (y !== 8'hFF) begin errors++; $display("[TB] FAIL bp_y6: got %h want ff", y); end
    checks++; if (parity !== 1'b0) begin errors++; $display("[TB] FAIL bp_parity6: got %b want 0", parity); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid7: got %b want 0", out_valid); end
    checks++; if (count !== 16'd3) begin errors++; $display("[TB] FAIL bp_count: got %0d want 3", count); end
  endtask

  task automatic test_width1;
    // Result for {a,b} = 0..3 as bit index, one entry per op code.
    logic [3:0] tt [8];
    int idx;
    tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b1100};
    tick();
    for (int i = 0; i < 34; i++) begin
      if (i < 32) begin
        w_in_valid = 1; w_op = 3'(i / 4); w_a = 1'((i % 4) >> 1); w_b = 1'(i % 4);
      end else begin
        w_in_valid = 0;
      end
      @(negedge clk);
      if (i >= 2) begin
        idx = i - 2;
        checks++; if (w_y !== tt[idx/4][idx%4]) begin errors++; $display("[TB] FAIL w1_y[op%0d ab%0d]: got %b want %b", idx / 4, idx % 4, w_y, tt[idx/4][idx%4]); end
      end
      tick();
    end
  endtask

  task automatic test_count_wrap;
    logic [1:0] seq [5];
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    tick();
    for (int i = 0; i < 8; i++) begin
      c_in_valid = (i < 5); c_a = 8'(i + 1);
      @(negedge clk);
      if (i >= 3) begin
        checks++; if (c_count !== seq[i-3]) begin errors++; $display("[TB] FAIL wrap_count[%0d]: got %0d want %0d", i - 3, c_count, seq[i-3]); end
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1;
    idle_inputs();
    w_in_valid = 0; w_a = 0; w_b = 0; w_op = 0;
    c_in_valid = 0; c_a = 0;
    test_reset();
    test_nand();
    test_ops();
    test_accumulate();
    test_reset_flush();
    test_backpressure();
    test_width1();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
